imm_pipe: RTL
=============

# imm_pipe

Buffered, parametrised immediate generator for the decode stage. It extracts and extends the I/S/B/U/J immediates and the CSR zimm from an incoming instruction. It tags each result with its format and carries a user tag alongside. Results sit in a DEPTH-entry FIFO between fetch and decode with valid/ready handshakes on both sides and a flush for redirects.

## Interface
- DATA_WIDTH, 32: immediate width; 32 or 64.
- DEPTH, 2: result FIFO entries; power of two, >= 2.
- TAG_WIDTH, 32: width of the passthrough tag (PC or ROB index).

Ports:
- i_sys_clk  in  1  clock.
- i_sys_rst  in  1  reset; synchronous, active-high.
- i_imm_flush  in  1  drop all buffered entries.
- i_imm_valid  in  1  instruction present.
- o_imm_ready  out  1  block can accept; equals (count != DEPTH).
- i_imm_inst  in  32  instruction word.
- i_imm_tag  in  TAG_WIDTH  tag stored with the result.
- o_imm_valid  out  1  head entry valid; equals (count != 0).
- i_imm_ready  in  1  consumer takes head.
- o_imm_data  out  DATA_WIDTH  head immediate.
- o_imm_type  out  3  head format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- o_imm_tag  out  TAG_WIDTH  head tag.
- o_imm_count  out  $clog2(DEPTH)+1  occupancy.

## Operation
Decode is combinational on the input; the result is written into the FIFO on push.

Push and pop conditions:
- push = i_imm_valid & o_imm_ready & ~i_imm_flush.
- pop = o_imm_valid & i_imm_ready.

Decode by opcode, i_imm_inst[6:0]:
- 1100111, 0000011, 0010011: type I; inst[31:20], sign-extended.
- 0011011: type I only when DATA_WIDTH==64; otherwise type none.
- 0100011: type S; {inst[31:25], inst[11:7]}, sign-extended.
- 1100011: type B; {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
- 0110111, 0010111: type U; {inst[31:12], 12'h0}, sign-extended from bit 31 to DATA_WIDTH.
- 1101111: type J; {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
- 1110011 with inst[14]==1: type Z; inst[19:15], zero-extended.
- Anything else, including 1110011 with inst[14]==0: type none, data 0. The entry is still pushed and the tag still carried.

FIFO:
- Circular buffer with read and write pointers of $clog2(DEPTH) bits; both wrap modulo DEPTH.
- count is updated as count + push - pop.
- The head fields o_imm_data, o_imm_type and o_imm_tag are read from storage at the read pointer.
- When the FIFO is empty, the head fields show the stale slot at the read pointer. The consumer must qualify them with o_imm_valid.

## Timing
Reset (synchronous, i_sys_rst high at a clock edge):
- Pointers and count go to 0, so o_imm_valid=0, o_imm_ready=1, o_imm_count=0.
- All storage is cleared, so o_imm_data=0, o_imm_type=0, o_imm_tag=0.
- Reset mid-stream discards all entries; no pop is reported in that cycle.

Latency and throughput:
- An entry pushed at edge N is visible at the head after edge N, i.e. 1-cycle latency.
- There is no combinational input-to-output path.
- Sustained throughput is 1 per cycle when the consumer is always ready.

Handshake rules:
- o_imm_ready depends only on registered count, so there is no combinational path from i_imm_ready to o_imm_ready.
- When full, o_imm_ready=0 even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pop when empty is impossible, because o_imm_valid=0.

Flush:
- i_imm_flush has priority over push and pop. Pointers and count go to 0 next cycle; storage is untouched.
- The input offered in a flush cycle is dropped.
- Reset takes priority over flush.

## Test plan
- Reset: hold i_sys_rst 2 cycles, then release -> o_imm_valid=0, o_imm_ready=1, count=0, o_imm_data=0, o_imm_type=0.
- Formats at DATA_WIDTH=32, consumer always ready, one per cycle:
  - 0xFFF00093 -> 0xFFFFFFFF, type 1.
  - 0xFE112E23 -> 0xFFFFFFFC, type 2.
  - 0x123450B7 -> 0x12345000, type 4.
  - 0xFF9FF06F -> 0xFFFFFFF8, type 5.
  - 0x3002D073 -> 0x00000005, type 6.
  - Each appears exactly 1 cycle after its push, with its tag.
- DATA_WIDTH=64:
  - 0x800000B7 -> 0xFFFFFFFF80000000, type 4.
  - 0x0010009B (addiw) -> 1, type 1; the same word at width 32 -> 0, type 0.
- Backpressure, DEPTH=2: hold i_imm_ready=0 and push 3 -> third stalls with o_imm_ready=0 and count=2. Release -> entries drain in order across pointer wrap, and the third then enters.
- Simultaneous push and pop at count=1 for 8 cycles -> count stays 1 and the order is preserved.
- Flush with count=2 and a valid input offered -> next cycle count=0, o_imm_valid=0, and the offered input never appears.

Source files
------------

// File: rtl/imm_pipe_if.sv
// Handshake bundle between fetch (producer), imm_pipe and decode (consumer).
// The slave modport is the imm_pipe view; master is the surrounding pipeline.
interface imm_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int TAG_WIDTH  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Producer side
  logic                  i_imm_flush;
  logic                  i_imm_valid;
  logic                  o_imm_ready;
  logic [31:0]           i_imm_inst;
  logic [TAG_WIDTH-1:0]  i_imm_tag;

  // Consumer side
  logic                  o_imm_valid;
  logic                  i_imm_ready;
  logic [DATA_WIDTH-1:0] o_imm_data;
  logic [2:0]            o_imm_type;
  logic [TAG_WIDTH-1:0]  o_imm_tag;
  logic [CNT_W-1:0]      o_imm_count;

  modport master (
    output i_imm_flush, i_imm_valid, i_imm_inst, i_imm_tag, i_imm_ready,
    input  o_imm_ready, o_imm_valid, o_imm_data, o_imm_type, o_imm_tag, o_imm_count
  );

  modport slave (
    input  i_imm_flush, i_imm_valid, i_imm_inst, i_imm_tag, i_imm_ready,
    output o_imm_ready, o_imm_valid, o_imm_data, o_imm_type, o_imm_tag, o_imm_count
  );
endinterface

// File: rtl/imm_pipe.sv
// Immediate generator with a DEPTH-entry result FIFO. The immediate is decoded
// combinationally from the offered instruction and written into the FIFO on
// push; the consumer always sees registered storage, so there is no
// combinational input-to-output path.
module imm_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int TAG_WIDTH  = 32
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  imm_pipe_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    imm_type_e             kind;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  // Sign-extend a 32-bit RISC-V immediate to the datapath width.
  function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
    logic [DATA_WIDTH-1:0] r;
    r       = {DATA_WIDTH{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] dec_data;
  imm_type_e             dec_type;

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  in_ready;
  logic                  out_valid;
  logic                  push;
  logic                  pop;

  assign inst = bus.i_imm_inst;

  // Opcode decode: pick the immediate format and assemble/extend its bits.
  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    dec_data = '0;
    dec_type = IMM_NONE;
    case (inst[6:0])
      7'b1100111, 7'b0000011, 7'b0010011: begin
        dec_type = IMM_I;
        dec_data = sext32({{20{inst[31]}}, inst[31:20]});
      end
      7'b0011011: begin
        // addiw and friends only exist on RV64.
        if (DATA_WIDTH == 64) begin
          dec_type = IMM_I;
          dec_data = sext32({{20{inst[31]}}, inst[31:20]});
        end
      end
      7'b0100011: begin
        dec_type = IMM_S;
        dec_data = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      7'b1100011: begin
        dec_type = IMM_B;
        dec_data = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                           inst[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec_type = IMM_U;
        dec_data = sext32({inst[31:12], 12'h000});
      end
      7'b1101111: begin
        dec_type = IMM_J;
        dec_data = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                           inst[30:21], 1'b0});
      end
      7'b1110011: begin
        // Only the CSR*I variants carry a zimm; ecall/ebreak/CSR reg forms do not.
        if (inst[14]) begin
          dec_type      = IMM_Z;
          dec_data[4:0] = inst[19:15];
        end
      end
      default: begin
        dec_type = IMM_NONE;
        dec_data = '0;
      end
    endcase
  end

  // Handshake flags come from registered count only, so i_imm_ready never
  // reaches o_imm_ready combinationally.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.i_imm_valid & in_ready & ~bus.i_imm_flush;
  assign pop       = out_valid & bus.i_imm_ready;

  // FIFO next state: flush drops everything but leaves storage untouched.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_imm_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{data: dec_data, kind: dec_type, tag: bus.i_imm_tag};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers with synchronous reset; reset wins over flush.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is cleared on reset because the head fields are
      // observable even when empty; a shallow FIFO keeps this cheap.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Head fields come straight from the slot at the read pointer.
  assign bus.o_imm_ready = in_ready;
  assign bus.o_imm_valid = out_valid;
  assign bus.o_imm_count = count_q;
  assign bus.o_imm_data  = mem_q[rd_ptr_q].data;
  assign bus.o_imm_type  = mem_q[rd_ptr_q].kind;
  assign bus.o_imm_tag   = mem_q[rd_ptr_q].tag;
endmodule
